// File: rtl/dual_ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
package dual_ram_arb_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/dual_ram_arb_if.sv
// Requester A/B handshakes plus the single RAM port, as seen by the arbiter (slave) and its environment (master).
interface dual_ram_arb_if #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 1
) ();

  logic              req_a, we_a, ack_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a, rdata_a;

  logic              req_b, we_b, ack_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b, rdata_b;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  logic              busy;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  ram_dout,
    output ack_a, rdata_a, ack_b, rdata_b,
    output ram_en, ram_we, ram_addr, ram_din,
    output busy
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output ram_dout,
    input  ack_a, rdata_a, ack_b, rdata_b,
    input  ram_en, ram_we, ram_addr, ram_din,
    input  busy
  );

endinterface

// File: rtl/dual_ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the last-grant pointer lives in the parent.
module rr_arb2
  import dual_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_id_c,
  output logic       gnt_valid_c
);

  always_comb begin
    gnt_valid_c = |req;
    gnt_id_c    = GNT_A;
    case (req)
      2'b01:   gnt_id_c = GNT_A;
      2'b10:   gnt_id_c = GNT_B;
      2'b11:   gnt_id_c = (last_grant == GNT_A) ? GNT_B : GNT_A;
      default: gnt_id_c = GNT_A;
    endcase
  end

endmodule

// File: rtl/dual_ram_arbiter.sv
// Round-robin sharing of one 1-cycle-latency RAM port between requesters A and B.
// Define DUAL_RAM_ARB_STATS_EN to add saturating per-requester grant counters.
module dual_ram_arbiter
  import dual_ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  dual_ram_arb_if.slave     bus
`ifdef DUAL_RAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt_a,
  output logic [STAT_W-1:0] grant_cnt_b
`endif
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic              busy_q, busy_d;

  logic [1:0]        req_vec;
  logic              gnt_id_c, gnt_valid_c;

  assign req_vec = {bus.req_b, bus.req_a};

  rr_arb2 u_rr_arb2 (
    .req         (req_vec),
    .last_grant  (last_grant_q),
    .gnt_id_c    (gnt_id_c),
    .gnt_valid_c (gnt_valid_c)
  );

  // Next state; the RAM command registers double as the latched request of the winner.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          gnt_d        = gnt_id_c;
          last_grant_d = gnt_id_c;
          ram_en_d     = 1'b1;
          ram_we_d     = (gnt_id_c == GNT_A) ? bus.we_a    : bus.we_b;
          ram_addr_d   = (gnt_id_c == GNT_A) ? bus.addr_a  : bus.addr_b;
          ram_din_d    = (gnt_id_c == GNT_A) ? bus.wdata_a : bus.wdata_b;
          state_d      = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (gnt_q == GNT_A) begin
          ack_a_d   = 1'b1;
          rdata_a_d = bus.ram_dout;
        end else begin
          ack_b_d   = 1'b1;
          rdata_b_d = bus.ram_dout;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_B;
      gnt_q        <= GNT_A;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ack_a    = ack_a_q;
  assign bus.ack_b    = ack_b_q;
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.busy     = busy_q;

`ifdef DUAL_RAM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  // Counters step together with the ack they count and stick at all-ones.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (ack_a_d && (cnt_a_q != {STAT_W{1'b1}})) cnt_a_d = cnt_a_q + STAT_W'(1);
    if (ack_b_d && (cnt_b_q != {STAT_W{1'b1}})) cnt_b_d = cnt_b_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Bench for dual_ram_arbiter: transaction-level reference of grants, memory and acks; honours DUAL_RAM_ARB_STATS_EN.
module tb_dual_ram_arbiter;
  import dual_ram_arb_pkg::*;

  localparam int unsigned DATA_W = 2;
  localparam int unsigned ADDR_W = 1;
  localparam int unsigned DEPTH  = 2;

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  always #5 clk = ~clk;

  dual_ram_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef DUAL_RAM_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_a, grant_cnt_b;
`endif

  dual_ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DUAL_RAM_ARB_STATS_EN
    ,
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
`endif
  );

  // Environment RAM: registered read, read-before-write.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) ram_mem[i] <= '0;
      bus.ram_dout <= '0;
    end else if (bus.ram_en) begin
      bus.ram_dout <= ram_mem[bus.ram_addr];
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_last_b;
  logic [DATA_W-1:0] ref_rdata_a, ref_rdata_b;
  int                ref_cnt_a, ref_cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(bus.ack_a === 1'b1 && bus.ack_b === 1'b1)) else begin
        errors++;
        $error("FAIL ack_exclusive: observed ack_a=%b ack_b=%b expected not both", bus.ack_a, bus.ack_b);
      end
    end
  end

  task automatic ref_reset();
    ref_last_b  = 1'b1;
    ref_rdata_a = '0;
    ref_rdata_b = '0;
    ref_cnt_a   = 0;
    ref_cnt_b   = 0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef DUAL_RAM_ARB_STATS_EN
    chk({tag, "_cnt_a"}, 32'(grant_cnt_a), ref_cnt_a);
    chk({tag, "_cnt_b"}, 32'(grant_cnt_b), ref_cnt_b);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack_a"},    32'(bus.ack_a),    0);
    chk({tag, "_ack_b"},    32'(bus.ack_b),    0);
    chk({tag, "_rdata_a"},  32'(bus.rdata_a),  0);
    chk({tag, "_rdata_b"},  32'(bus.rdata_b),  0);
    chk({tag, "_ram_en"},   32'(bus.ram_en),   0);
    chk({tag, "_ram_we"},   32'(bus.ram_we),   0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
    chk({tag, "_ram_din"},  32'(bus.ram_din),  0);
    chk({tag, "_busy"},     32'(bus.busy),     0);
    chk_stats(tag);
  endtask

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  // One round: requesters raise req together, each drops it in its ack cycle.
  task automatic do_txn(input bit ua, input bit wa, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                        input bit ub, input bit wb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    bit                who [2];
    int                n, na, nb, cyc_a, cyc_b;
    logic [DATA_W-1:0] exp_a, exp_b;
    bit                exp_en, first_b;
    first_b = ub && (!ua || !ref_last_b);
    n = 0;
    if (first_b) begin
      who[n] = 1'b1; n++;
      if (ua) begin who[n] = 1'b0; n++; end
    end else begin
      if (ua) begin who[n] = 1'b0; n++; end
      if (ub) begin who[n] = 1'b1; n++; end
    end
    exp_a = '0; exp_b = '0; cyc_a = 0; cyc_b = 0;
    for (int k = 0; k < n; k++) begin
      if (!who[k]) begin
        exp_a = ref_mem[aa];
        if (wa) ref_mem[aa] = da;
        cyc_a = 3 * (k + 1);
        ref_cnt_a = sat_inc(ref_cnt_a);
      end else begin
        exp_b = ref_mem[ab];
        if (wb) ref_mem[ab] = db;
        cyc_b = 3 * (k + 1);
        ref_cnt_b = sat_inc(ref_cnt_b);
      end
      ref_last_b = who[k];
    end

    bus.req_a = ua; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
    bus.req_b = ub; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
    na = 0; nb = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      exp_en = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (cyc == 3 * k + 1) begin
          exp_en = 1'b1;
          chk("ram_we",   32'(bus.ram_we),   32'(who[k] ? wb : wa));
          chk("ram_addr", 32'(bus.ram_addr), 32'(who[k] ? ab : aa));
          if (who[k] ? wb : wa) chk("ram_din", 32'(bus.ram_din), 32'(who[k] ? db : da));
        end
      end
      chk("ram_en", 32'(bus.ram_en), 32'(exp_en));
      if (cyc == 1 && n > 0) chk("busy_active", 32'(bus.busy), 1);
      if (bus.ack_a === 1'b1) begin
        chk("ack_a_cycle", cyc, cyc_a);
        chk("rdata_a", 32'(bus.rdata_a), 32'(exp_a));
        chk("rdata_b_hold", 32'(bus.rdata_b), 32'(ref_rdata_b));
        ref_rdata_a = exp_a;
        bus.req_a = 1'b0;
        na++;
      end
      if (bus.ack_b === 1'b1) begin
        chk("ack_b_cycle", cyc, cyc_b);
        chk("rdata_b", 32'(bus.rdata_b), 32'(exp_b));
        chk("rdata_a_hold", 32'(bus.rdata_a), 32'(ref_rdata_a));
        ref_rdata_b = exp_b;
        bus.req_b = 1'b0;
        nb++;
      end
    end
    chk("ack_a_count", na, 32'(ua));
    chk("ack_b_count", nb, 32'(ub));
    chk("busy_idle", 32'(bus.busy), 0);
    chk_stats("txn");
  endtask

  task automatic rand_txn();
    do_txn(1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
           1'($urandom), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
  endtask

  // Both requesters hold req straight through their acks: grants must alternate.
  task automatic hold_contention(input int nacc);
    logic [ADDR_W-1:0] aa, ab;
    bit                nxt_b;
    int                k;
    aa = ADDR_W'($urandom);
    ab = ADDR_W'($urandom);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = aa; bus.wdata_a = '0;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = ab; bus.wdata_b = '0;
    nxt_b = !ref_last_b;
    k = 0;
    for (int cyc = 1; cyc <= 3 * nacc + 3; cyc++) begin
      step();
      if (bus.ack_a === 1'b1 || bus.ack_b === 1'b1) begin
        chk("hold_cycle", cyc, 3 * (k + 1));
        chk("hold_winner", 32'(bus.ack_b), 32'(nxt_b));
        if (nxt_b) begin
          chk("hold_rdata_b", 32'(bus.rdata_b), 32'(ref_mem[ab]));
          ref_rdata_b = ref_mem[ab];
          ref_cnt_b = sat_inc(ref_cnt_b);
        end else begin
          chk("hold_rdata_a", 32'(bus.rdata_a), 32'(ref_mem[aa]));
          ref_rdata_a = ref_mem[aa];
          ref_cnt_a = sat_inc(ref_cnt_a);
        end
        ref_last_b = nxt_b;
        nxt_b = !nxt_b;
        k++;
        if (k == nacc) begin
          bus.req_a = 1'b0;
          bus.req_b = 1'b0;
        end
      end
    end
    chk("hold_acks", k, nacc);
    chk_stats("hold");
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ram_clr = 1'b1;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    ref_reset();
    step(); step();
    chk_all_zero("reset");
    ram_clr = 1'b0; rst = 1'b0;
    step();

    // Tie straight after reset: A (addr 0) then B (addr 1)
    do_txn(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
    // A writes addr 1 then reads it back
    do_txn(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    do_txn(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    // Read-before-write on addr 0
    do_txn(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
    do_txn(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 2'b11);
    do_txn(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

    hold_contention(8);

    for (int i = 0; i < 24; i++) rand_txn();

    // Reset while an A read sits in ACCESS, after A was the last winner
    do_txn(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 1'b1;
    step();
    chk("abort_busy",   32'(bus.busy),   1);
    chk("abort_ram_en", 32'(bus.ram_en), 1);
    rst = 1'b1;
    step();
    ref_reset();
    chk_all_zero("abort");
    rst = 1'b0; bus.req_a = 1'b0;
    step();
    chk("abort_no_ack", 32'(bus.ack_a), 0);
    do_txn(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);

    // 5 A and 3 B transactions from a clean count
    rst = 1'b1; step(); rst = 1'b0; ref_reset(); step();
    for (int i = 0; i < 5; i++) do_txn(1'b1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) do_txn(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
    chk_stats("stats");
    rst = 1'b1; step(); rst = 1'b0; ref_reset();
    chk_all_zero("final_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
